// File: rtl/hqm_system_rf_fifo_ctl_64x30_if.sv
`timescale 1ns/1ps
// Bus bundle for the RF-backed FIFO controller.
// Groups the push stream, pop stream, flush, status outputs and the two RF ports.
// slave  : the controller's view.
// master : the surrounding logic's view (producer, consumer and RF macro).
interface hqm_system_rf_fifo_ctl_64x30_if #(
  parameter int unsigned DWIDTH = 30,
  parameter int unsigned AWIDTH = 6
);
  logic              flush;
  logic              push_valid;
  logic              push_ready;
  logic [DWIDTH-1:0] push_data;
  logic              pop_valid;
  logic              pop_ready;
  logic [DWIDTH-1:0] pop_data;
  logic [AWIDTH:0]   count;
  logic              empty;
  logic              full;
  logic              mem_we;
  logic [AWIDTH-1:0] mem_waddr;
  logic [DWIDTH-1:0] mem_wdata;
  logic              mem_re;
  logic [AWIDTH-1:0] mem_raddr;
  logic [DWIDTH-1:0] mem_rdata;

  modport slave (
    input  flush, push_valid, push_data, pop_ready, mem_rdata,
    output push_ready, pop_valid, pop_data, count, empty, full,
           mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
  );

  modport master (
    output flush, push_valid, push_data, pop_ready, mem_rdata,
    input  push_ready, pop_valid, pop_data, count, empty, full,
           mem_we, mem_waddr, mem_wdata, mem_re, mem_raddr
  );
endinterface

// File: rtl/hqm_system_rf_fifo_ctl_64x30.sv
`timescale 1ns/1ps
// FIFO controller for a 64x30 two-port RF with one-cycle registered read data.
// Pushes are written straight into the RF; reads are prefetched into a 2-entry
// output buffer so the pop side can sustain one transfer per cycle.
// Ports:
//   clk  : single clock shared by both RF ports
//   rst  : asynchronous active-high reset
//   bus  : push/pop streams, flush, count/empty/full and RF write/read ports
module hqm_system_rf_fifo_ctl_64x30 #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned DWIDTH = 30,
  parameter int unsigned AWIDTH = 6
) (
  input logic                          clk,
  input logic                          rst,
  hqm_system_rf_fifo_ctl_64x30_if.slave bus
);

  localparam logic [AWIDTH:0] DepthCnt = (AWIDTH+1)'(DEPTH);

  logic [AWIDTH-1:0] wptr_q, wptr_d;
  logic [AWIDTH-1:0] rptr_q, rptr_d;
  logic [AWIDTH:0]   rf_cnt_q, rf_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic [DWIDTH-1:0] buf_q [2];
  logic [DWIDTH-1:0] buf_d [2];
  logic [1:0]        buf_cnt_q, buf_cnt_d;

  logic [AWIDTH:0]   count;
  logic              push_ready, push_fire;
  logic              pop_valid, pop_fire;
  logic              mem_re;
  logic [2:0]        occ_after_pop;
  logic [1:0]        buf_cnt_shift;

  assign count = rf_cnt_q + (AWIDTH+1)'(rd_pend_q) + (AWIDTH+1)'(buf_cnt_q);

  always_comb begin
    push_ready = (count < DepthCnt) && !bus.flush && !rst;
    push_fire  = bus.push_valid && push_ready;
    pop_valid  = (buf_cnt_q != 2'd0) && !bus.flush;
    pop_fire   = pop_valid && bus.pop_ready;
    // Buffer slots that will be claimed once this cycle's pop is applied; a new
    // read may only launch if its data is guaranteed a slot next cycle.
    occ_after_pop = {1'b0, buf_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop_fire};
    mem_re        = (rf_cnt_q != '0) && (occ_after_pop < 3'd2) && !bus.flush;
  end

  always_comb begin
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    rf_cnt_d      = rf_cnt_q;
    rd_pend_d     = 1'b0;
    buf_d[0]      = buf_q[0];
    buf_d[1]      = buf_q[1];
    buf_cnt_d     = buf_cnt_q;
    buf_cnt_shift = buf_cnt_q;
    if (bus.flush) begin
      // Clearing rd_pend drops the read data returning next cycle.
      wptr_d    = '0;
      rptr_d    = '0;
      rf_cnt_d  = '0;
      buf_d[0]  = '0;
      buf_d[1]  = '0;
      buf_cnt_d = '0;
    end else begin
      if (push_fire) wptr_d = wptr_q + 1'b1;
      if (mem_re)    rptr_d = rptr_q + 1'b1;
      rd_pend_d = mem_re;
      rf_cnt_d  = rf_cnt_q + (AWIDTH+1)'(push_fire) - (AWIDTH+1)'(mem_re);
      if (pop_fire) begin
        buf_d[0]      = buf_q[1];
        buf_cnt_shift = buf_cnt_q - 2'd1;
      end
      // Returning read data lands in the first free slot after the shift.
      if (rd_pend_q) begin
        if (buf_cnt_shift == 2'd0) buf_d[0] = bus.mem_rdata;
        else                       buf_d[1] = bus.mem_rdata;
        buf_cnt_d = buf_cnt_shift + 2'd1;
      end else begin
        buf_cnt_d = buf_cnt_shift;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      rf_cnt_q  <= '0;
      rd_pend_q <= 1'b0;
      buf_q[0]  <= '0;
      buf_q[1]  <= '0;
      buf_cnt_q <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      rf_cnt_q  <= rf_cnt_d;
      rd_pend_q <= rd_pend_d;
      buf_q[0]  <= buf_d[0];
      buf_q[1]  <= buf_d[1];
      buf_cnt_q <= buf_cnt_d;
    end
  end

  assign bus.push_ready = push_ready;
  assign bus.pop_valid  = pop_valid;
  assign bus.pop_data   = buf_q[0];
  assign bus.count      = count;
  assign bus.empty      = (count == '0);
  assign bus.full       = (count == DepthCnt);
  assign bus.mem_we     = push_fire;
  assign bus.mem_waddr  = wptr_q;
  assign bus.mem_wdata  = bus.push_data;
  assign bus.mem_re     = mem_re;
  assign bus.mem_raddr  = rptr_q;

  occupancy_bound_a: assert property (@(posedge clk) disable iff (rst)
    (rf_cnt_q <= DepthCnt) && (count <= DepthCnt));

endmodule

// File: tb/tb_hqm_system_rf_fifo_ctl_64x30.sv
`timescale 1ns/1ps
// Bench for the RF FIFO controller: an RF macro model, a queue-based reference
// model checked every cycle, and directed scenarios with literal expectations.
module tb_hqm_system_rf_fifo_ctl_64x30;
  localparam int DW = 30;
  localparam int AW = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hqm_system_rf_fifo_ctl_64x30_if #(.DWIDTH(DW), .AWIDTH(AW)) f ();

  hqm_system_rf_fifo_ctl_64x30 #(.DEPTH(DEPTH), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (f)
  );

  // RF macro: synchronous write, one-cycle registered read.
  logic [DW-1:0] rf_mem [DEPTH];
  logic [DW-1:0] rdata_q = '0;
  initial for (int i = 0; i < DEPTH; i++) rf_mem[i] = '0;
  always @(posedge clk) begin
    if (f.mem_re) rdata_q <= rf_mem[f.mem_raddr];
    if (f.mem_we) rf_mem[f.mem_waddr] <= f.mem_wdata;
  end
  assign f.mem_rdata = rdata_q;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO contents with the cycle each entry was accepted.
  // An entry crosses the RF and the output buffer in exactly 3 cycles, and the
  // prefetch keeps the head in the buffer whenever it is at least that old.
  logic [DW-1:0] q_data[$];
  int            q_time[$];
  int            m_wptr = 0;
  int            cyc = 0;

  always @(negedge clk) begin
    logic exp_pr, exp_pv;
    if (rst) begin
      chk("rst_pop_valid", f.pop_valid, 0);
      chk("rst_push_ready", f.push_ready, 0);
      chk("rst_count", f.count, 0);
      chk("rst_empty", f.empty, 1);
      chk("rst_mem_we", f.mem_we, 0);
      chk("rst_mem_re", f.mem_re, 0);
      q_data.delete();
      q_time.delete();
      m_wptr = 0;
    end else begin
      exp_pr = (q_data.size() < DEPTH) && !f.flush;
      exp_pv = 1'b0;
      if (!f.flush && q_data.size() != 0) exp_pv = (cyc - q_time[0]) >= 3;
      chk("m_push_ready", f.push_ready, exp_pr);
      chk("m_count", f.count, q_data.size());
      chk("m_empty", f.empty, q_data.size() == 0);
      chk("m_full", f.full, q_data.size() == DEPTH);
      chk("m_pop_valid", f.pop_valid, exp_pv);
      if (exp_pv) chk("m_pop_data", f.pop_data, q_data[0]);
      chk("m_mem_we", f.mem_we, f.push_valid && exp_pr);
      if (f.push_valid && exp_pr) begin
        chk("m_mem_waddr", f.mem_waddr, m_wptr);
        chk("m_mem_wdata", f.mem_wdata, f.push_data);
      end
      if (f.flush) begin
        q_data.delete();
        q_time.delete();
        m_wptr = 0;
      end else begin
        if (exp_pv && f.pop_ready) begin
          void'(q_data.pop_front());
          void'(q_time.pop_front());
        end
        if (f.push_valid && exp_pr) begin
          q_data.push_back(f.push_data);
          q_time.push_back(cyc);
          m_wptr = (m_wptr + 1) % DEPTH;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    f.push_valid = 1'b0;
    f.pop_ready  = 1'b1;
    for (int k = 0; k < 200 && !f.empty; k++) tick();
    #1;
    chk(name, f.empty, 1);
    f.pop_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int exp_i;
    rst          = 1'b1;
    f.flush      = 1'b0;
    f.push_valid = 1'b0;
    f.push_data  = '0;
    f.pop_ready  = 1'b0;
    #2;
    chk("reset_pop_valid", f.pop_valid, 0);
    chk("reset_push_ready", f.push_ready, 0);
    chk("reset_count", f.count, 0);
    chk("reset_empty", f.empty, 1);
    chk("reset_full", f.full, 0);
    chk("reset_mem_we", f.mem_we, 0);
    chk("reset_mem_re", f.mem_re, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("release_push_ready", f.push_ready, 1);

    // Single push: write at cycle 0, read at 1, pop visible at 3.
    tick(); f.push_valid = 1'b1; f.push_data = 30'h155; #1;
    chk("sp_mem_we", f.mem_we, 1);
    chk("sp_waddr", f.mem_waddr, 0);
    chk("sp_wdata", f.mem_wdata, 30'h155);
    tick(); f.push_valid = 1'b0; #1;
    chk("sp_mem_re", f.mem_re, 1);
    chk("sp_raddr", f.mem_raddr, 0);
    chk("sp_count1", f.count, 1);
    chk("sp_pv_c1", f.pop_valid, 0);
    tick(); #1;
    chk("sp_pv_c2", f.pop_valid, 0);
    tick(); f.pop_ready = 1'b1; #1;
    chk("sp_pv_c3", f.pop_valid, 1);
    chk("sp_pop_data", f.pop_data, 30'h155);
    chk("sp_count_c3", f.count, 1);
    tick(); f.pop_ready = 1'b0; #1;
    chk("sp_count0", f.count, 0);
    chk("sp_empty", f.empty, 1);

    // Fill to 64, reject a 65th, drain in order.
    for (int i = 0; i < DEPTH; i++) begin
      tick(); f.push_valid = 1'b1; f.push_data = DW'(i);
    end
    tick(); f.push_valid = 1'b1; f.push_data = 30'h3fffffff; #1;
    chk("fill_full", f.full, 1);
    chk("fill_push_ready", f.push_ready, 0);
    chk("fill_count", f.count, 64);
    chk("fill_65th_we", f.mem_we, 0);
    exp_i = 0;
    for (int k = 0; k < 120 && exp_i < DEPTH; k++) begin
      tick(); f.push_valid = 1'b0; f.pop_ready = 1'b1; #1;
      if (f.pop_valid) begin
        chk("drain_data", f.pop_data, exp_i);
        exp_i++;
      end
    end
    chk("drain_total", exp_i, 64);
    tick(); f.pop_ready = 1'b0; #1;
    chk("drain_empty", f.empty, 1);

    // Throughput: push and pop every cycle; no bubbles after 3-cycle warm-up.
    for (int i = 0; i < 200; i++) begin
      tick(); f.push_valid = 1'b1; f.push_data = DW'(1000 + i); f.pop_ready = 1'b1; #1;
      if (i >= 3) chk("tput_pop_valid", f.pop_valid, 1);
    end
    tick();
    drain("tput_drain_empty");

    // Backpressure: random pushes, pop_ready about 30%.
    for (int i = 0; i < 400; i++) begin
      tick();
      f.push_valid = ($urandom_range(0, 9) < 7);
      f.push_data  = DW'($urandom);
      f.pop_ready  = ($urandom_range(0, 9) < 3);
      #1;
      chk("bp_count_bound", f.count <= 64, 1);
    end
    tick();
    drain("bp_drain_empty");

    // Flush right after a read launches with 10 entries queued.
    for (int i = 0; i < 11; i++) begin
      tick(); f.push_valid = 1'b1; f.push_data = DW'(500 + i);
    end
    tick(); f.push_valid = 1'b0;
    repeat (2) tick();
    tick(); f.pop_ready = 1'b1; #1;
    chk("fl_pre_mem_re", f.mem_re, 1);
    chk("fl_pre_count", f.count, 11);
    tick(); f.pop_ready = 1'b0; f.flush = 1'b1; f.push_valid = 1'b1; f.push_data = 30'h7; #1;
    chk("fl_count_queued", f.count, 10);
    chk("fl_pop_valid", f.pop_valid, 0);
    chk("fl_push_ready", f.push_ready, 0);
    chk("fl_mem_we", f.mem_we, 0);
    chk("fl_mem_re", f.mem_re, 0);
    tick(); f.flush = 1'b0; f.push_valid = 1'b0; #1;
    chk("fl_post_count", f.count, 0);
    chk("fl_post_pop_valid", f.pop_valid, 0);
    tick(); f.push_valid = 1'b1; f.push_data = 30'h3;
    tick(); f.push_valid = 1'b0;
    tick();
    tick(); f.pop_ready = 1'b1; #1;
    chk("fl_after_pv", f.pop_valid, 1);
    chk("fl_after_data", f.pop_data, 30'h3);
    tick(); f.pop_ready = 1'b0; #1;
    chk("fl_after_empty", f.empty, 1);

    // Asynchronous reset with 20 entries queued.
    for (int i = 0; i < 20; i++) begin
      tick(); f.push_valid = 1'b1; f.push_data = DW'(900 + i);
    end
    tick(); f.push_valid = 1'b0; #1;
    chk("ar_count20", f.count, 20);
    #1 rst = 1'b1;
    #1;
    chk("ar_pop_valid", f.pop_valid, 0);
    chk("ar_push_ready", f.push_ready, 0);
    chk("ar_count", f.count, 0);
    chk("ar_empty", f.empty, 1);
    chk("ar_full", f.full, 0);
    tick();
    tick(); rst = 1'b0; #1;
    chk("ar_rel_push_ready", f.push_ready, 1);
    chk("ar_rel_empty", f.empty, 1);
    tick(); f.push_valid = 1'b1; f.push_data = 30'h2aaaaaaa; #1;
    chk("ar_waddr0", f.mem_waddr, 0);
    tick(); f.push_valid = 1'b0;
    tick();
    tick(); f.pop_ready = 1'b1; #1;
    chk("ar_pv", f.pop_valid, 1);
    chk("ar_data", f.pop_data, 30'h2aaaaaaa);
    tick(); f.pop_ready = 1'b0; #1;
    chk("ar_final_empty", f.empty, 1);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hqm_system_rf_fifo_ctl_64x30.md
# hqm_system_rf_fifo_ctl_64x30

Synchronous FIFO controller that drives a 64-entry x 30-bit two-port register-file macro with one-cycle registered read data. It sits directly upstream and downstream of the RF. It turns a valid/ready push stream into RF writes. It prefetches RF reads into a 2-entry output buffer so the valid/ready pop stream runs at full rate. Both RF ports run on the single block clock.

## Interface
- DEPTH, 64: RF entries; power of two.
- DWIDTH, 30: data width.
- AWIDTH, 6: log2(DEPTH).
- clk  in  1: single clock; the RF wclk and rclk are tied to it.
- rst  in  1: asynchronous, active-high reset.
- flush  in  1: synchronous clear of all FIFO state.
- push_valid  in  1: push request.
- push_ready  out  1: push accepted when push_valid && push_ready.
- push_data  in  DWIDTH: push payload.
- pop_valid  out  1: head entry valid.
- pop_ready  in  1: consumer accepts the head entry.
- pop_data  out  DWIDTH: head entry.
- count  out  AWIDTH+1: total occupancy (RF + in-flight read + buffer), 0..64.
- empty  out  1: count==0.
- full  out  1: count==64.
- mem_we  out  1: RF write enable.
- mem_waddr  out  AWIDTH: RF write address.
- mem_wdata  out  DWIDTH: RF write data.
- mem_re  out  1: RF read enable.
- mem_raddr  out  AWIDTH: RF read address.
- mem_rdata  in  DWIDTH: RF read data, valid the cycle after mem_re.

## Operation
- State:
  - wptr and rptr: AWIDTH bits, wrap 63->0 naturally.
  - rf_cnt: 0..64, entries written but not yet read.
  - rd_pend: one bit, read in flight.
  - Output buffer buf[0..1] with buf_cnt 0..2; buf[0] is the head.
  - count = rf_cnt + rd_pend + buf_cnt; at most 64.
- Push side:
  - push_fire = push_valid && push_ready && !flush.
  - push_ready = (count < 64) && !flush && !rst.
  - mem_we = push_fire, mem_waddr = wptr, mem_wdata = push_data, all combinational.
  - On push_fire: wptr++ and rf_cnt++.
- Pop side:
  - pop_valid = (buf_cnt != 0) && !flush.
  - pop_data = buf[0].
  - pop_fire = pop_valid && pop_ready.
  - On pop_fire: shift buf[1] into buf[0] and decrement buf_cnt.
- Prefetch:
  - mem_re = (rf_cnt != 0) && (buf_cnt + rd_pend - pop_fire < 2) && !flush.
  - mem_raddr = rptr.
  - On mem_re: rptr++, rf_cnt--, rd_pend <= 1. Otherwise rd_pend <= 0.
  - When rd_pend == 1: mem_rdata is written into the first free buffer slot after the pop shift is applied, and buf_cnt is incremented.
- Simultaneous events:
  - Push and read in the same cycle: rf_cnt is unchanged.
  - A read never targets the slot written in the same cycle, because rf_cnt counts only prior writes.
- Flush takes priority over push and pop. It clears wptr, rptr, rf_cnt, rd_pend, buf_cnt and buf valid. Read data returning in the cycle after a flush is discarded.
- RF overflow and underflow cannot occur by construction. An assertion is required: rf_cnt <= 64 && count <= 64.
- Data ordering is strict FIFO. There is no write-to-read bypass; all data passes through the RF.

## Timing
- Reset values: pop_valid=0, push_ready=0 (1 the first cycle after rst deasserts), count=0, empty=1, full=0, mem_we=0, mem_re=0. Pointers, rf_cnt, rd_pend and buf_cnt are 0. buf data is 0.
- Push-to-pop latency into an empty FIFO is 3 cycles:
  - Cycle N: push_fire, mem_we.
  - Cycle N+1: mem_re.
  - Cycle N+2: mem_rdata captured.
  - Cycle N+3: pop_valid=1.
- Steady state: one push and one pop per cycle sustained, once buf_cnt==2 or a read is pending.
- count, empty and full update on the clock edge after the causing fire.
- full deasserts the cycle after the pop_fire that frees an entry. push_ready follows the same cycle.
- Reset asserted mid-operation: all state clears immediately and asynchronously. RF contents are don't-care.

## Test plan
- Single push: push 30'h155 at cycle 0 -> mem_we with waddr=0 at cycle 0; mem_re with raddr=0 at cycle 1; pop_valid with pop_data=30'h155 at cycle 3; count 1 then 0 after the pop.
- Fill then drain: 64 pushes with pop_ready=0 -> full=1, push_ready=0, count=64, and a 65th push is not accepted. Drain -> data 0..63 in order, empty=1.
- Throughput: continuous push and pop with pop_ready=1 for 200 cycles -> after warm-up, one pop per cycle with no bubbles. Pointers wrap past 63 and ordering is preserved.
- Backpressure: random pop_ready at 30% -> buf_cnt never exceeds 2, no data lost or duplicated, and the count invariant holds every cycle.
- Flush: flush in the cycle after a mem_re with 10 entries queued -> the next cycle has count=0 and pop_valid=0, and the returning mem_rdata is ignored. A subsequent push of 30'h3 pops as 30'h3.
- Async reset: assert rst mid-stream with count=20 -> outputs are at reset values within the same cycle. After release, the FIFO behaves as empty.
